// File: rtl/bk_adder_arbiter.sv
// Round-robin shared 64-bit Brent-Kung add/subtract unit with a one-entry
// registered response buffer. Subtract is a + ~b + 1.

module BrentKungAdder64Bit (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  localparam int W  = 32'sd64;
  localparam int LG = 32'sd6;

  logic [63:0] gen_s;

  // Brent-Kung prefix tree: up-sweep builds power-of-two spans, down-sweep fills the gaps; cin is folded into bit 0
  always_comb begin : prefix_tree
    logic [63:0] g_v;
    logic [63:0] p_v;
    logic [5:0]  ii;
    logic [5:0]  jj;
    g_v    = a & b;
    p_v    = a ^ b;
    g_v[0] = g_v[0] | (p_v[0] & cin);
    ii     = 6'd0;
    jj     = 6'd0;
    for (int l = 32'sd0; l < LG; l++) begin
      for (int i = 32'sd0; i < W; i++) begin
        ii = 6'(i);
        jj = (i >= (32'sd1 << l)) ? 6'(i - (32'sd1 << l)) : 6'd0;
        if (((i + 32'sd1) % (32'sd2 << l)) == 32'sd0) begin
          g_v[ii] = g_v[ii] | (p_v[ii] & g_v[jj]);
          p_v[ii] = p_v[ii] & p_v[jj];
        end else begin
          g_v[ii] = g_v[ii];
        end
      end
    end
    for (int l = LG - 32'sd2; l >= 32'sd0; l--) begin
      for (int i = 32'sd0; i < W; i++) begin
        ii = 6'(i);
        jj = (i >= (32'sd1 << l)) ? 6'(i - (32'sd1 << l)) : 6'd0;
        if ((i >= ((32'sd3 << l) - 32'sd1)) &&
            (((i + 32'sd1 + (32'sd1 << l)) % (32'sd2 << l)) == 32'sd0)) begin
          g_v[ii] = g_v[ii] | (p_v[ii] & g_v[jj]);
        end else begin
          g_v[ii] = g_v[ii];
        end
      end
    end
    gen_s = g_v;
  end

  assign sum  = (a ^ b) ^ {gen_s[62:0], cin};
  assign cout = gen_s[63];

endmodule

module bk_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [NREQ-1:0]      req_cin,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [63:0]          rsp_sum,
  output logic                 rsp_cout,
  output logic                 rsp_ovf,
  output logic [ID_W-1:0]      rsp_id
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   win_s;
  logic              any_s;
  logic              can_accept_s;
  logic              grant_s;
  logic [2*NREQ-1:0] rot_dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [63:0]       op_a_s;
  logic [63:0]       op_b_s;
  logic              op_sub_s;
  logic              op_cin_s;
  logic [63:0]       b_eff_s;
  logic              cin_eff_s;
  logic [63:0]       sum_s;
  logic              cout_s;
  logic              ovf_s;
  logic [63:0]       rsp_sum_r;
  logic              rsp_cout_r;
  logic              rsp_ovf_r;
  logic [ID_W-1:0]   rsp_id_r;

  // Rotating the valids by rr_ptr makes the scan start at bit 0
  assign rot_dbl_s = {req_valid, req_valid} >> rr_ptr_r;
  assign rot_s     = rot_dbl_s[NREQ-1:0];

  // Round-robin winner: first valid requester at or after rr_ptr
  always_comb begin : arbiter
    logic found;
    found = 1'b0;
    win_s = '0;
    for (int k = 32'sd0; k < NREQ; k++) begin
      if (!found && rot_s[k]) begin
        found = 1'b1;
        win_s = ID_W'((int'(rr_ptr_r) + k) % NREQ);
      end else begin
        found = found;
      end
    end
    any_s = found;
  end

  assign can_accept_s = (state_r == EMPTY) || rsp_ready;
  assign grant_s      = rst_n && can_accept_s && any_s;
  assign req_ready    = grant_s ? ({{(NREQ-1){1'b0}}, 1'b1} << win_s) : {NREQ{1'b0}};

  // Select the winner's operands
  always_comb begin : operand_mux
    op_a_s   = 64'd0;
    op_b_s   = 64'd0;
    op_sub_s = 1'b0;
    op_cin_s = 1'b0;
    for (int i = 32'sd0; i < NREQ; i++) begin
      if (win_s == ID_W'(i)) begin
        op_a_s   = req_a[64*i +: 64];
        op_b_s   = req_b[64*i +: 64];
        op_sub_s = req_sub[i];
        op_cin_s = req_cin[i];
      end else begin
        op_a_s   = op_a_s;
      end
    end
  end

  assign b_eff_s   = op_sub_s ? ~op_b_s : op_b_s;
  assign cin_eff_s = op_sub_s ? 1'b1 : op_cin_s;

  BrentKungAdder64Bit u_adder (
    .a    (op_a_s),
    .b    (b_eff_s),
    .cin  (cin_eff_s),
    .sum  (sum_s),
    .cout (cout_s)
  );

  assign ovf_s = (op_a_s[63] == b_eff_s[63]) && (sum_s[63] != op_a_s[63]);

  // Buffer next-state: a grant always fills; an accepted response with no grant empties
  always_comb begin : buffer_next
    state_nxt_s = state_r;
    case (state_r)
      EMPTY:   state_nxt_s = grant_s ? FULL : EMPTY;
      FULL:    state_nxt_s = (rsp_ready && !grant_s) ? EMPTY : FULL;
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Buffer state, round-robin pointer and response payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      rr_ptr_r   <= '0;
      rsp_sum_r  <= 64'd0;
      rsp_cout_r <= 1'b0;
      rsp_ovf_r  <= 1'b0;
      rsp_id_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_s) begin
        rr_ptr_r   <= (win_s == ID_W'(NREQ - 1)) ? '0 : win_s + 1'b1;
        rsp_sum_r  <= sum_s;
        rsp_cout_r <= cout_s;
        rsp_ovf_r  <= ovf_s;
        rsp_id_r   <= win_s;
      end else begin
        rr_ptr_r   <= rr_ptr_r;
      end
    end
  end

  assign rsp_valid = (state_r == FULL);
  assign rsp_sum   = rsp_sum_r;
  assign rsp_cout  = rsp_cout_r;
  assign rsp_ovf   = rsp_ovf_r;
  assign rsp_id    = rsp_id_r;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Directed + randomized bench for bk_adder_arbiter against a reference model
// built from plain wide arithmetic and a round-robin scan.

module tb_bk_adder_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [64*NREQ-1:0]   req_a;
  logic [64*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_sub;
  logic [NREQ-1:0]      req_cin;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [63:0]          rsp_sum;
  logic                 rsp_cout;
  logic                 rsp_ovf;
  logic [ID_W-1:0]      rsp_id;

  bk_adder_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_ptr;
  bit          m_valid;
  logic [63:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  int          m_id;
  logic [NREQ-1:0] g_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  // Result of requester w's operation, from plain signed/unsigned arithmetic
  task automatic compute(input int w, output logic [63:0] s, output logic co, output logic ov);
    logic [63:0]        a, b;
    logic [64:0]        u;
    logic signed [65:0] t;
    a = req_a[64*w +: 64];
    b = req_b[64*w +: 64];
    if (req_sub[w]) begin
      s  = a - b;
      co = (a >= b);
      t  = $signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b});
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {64'd0, req_cin[w]};
      s  = u[63:0];
      co = u[64];
      t  = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}) + $signed({65'd0, req_cin[w]});
    end
    ov = !((t[65] == t[64]) && (t[64] == t[63]));
  endtask

  // One clock: check at the falling edge, then advance the model on the rising edge
  task automatic cycle();
    int w;
    bit can;
    logic [NREQ-1:0] er;
    logic [63:0] s;
    logic co, ov;
    @(negedge clk);
    can = !m_valid || rsp_ready;
    w   = pick();
    er  = '0;
    if (can && w >= 0) er[w] = 1'b1;
    g_ready = req_ready;
    chk("req_ready", req_ready, er);
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_sum", rsp_sum, m_sum);
      chk("rsp_cout", rsp_cout, m_cout);
      chk("rsp_ovf", rsp_ovf, m_ovf);
      chk("rsp_id", rsp_id, m_id);
    end
    if (can && w >= 0) compute(w, s, co, ov);
    @(posedge clk);
    if (can && w >= 0) begin
      m_valid = 1'b1;
      m_sum = s; m_cout = co; m_ovf = ov; m_id = w;
      m_ptr = (w + 1) % NREQ;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_id = 0;
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin);
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_sub[i] = sub;
    req_cin[i] = cin;
  endtask

  int order [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    req_sub = '0; req_cin = '0; rsp_ready = 1'b0;
    model_reset();
    req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 4'b0000);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_sum", rsp_sum, 64'd0);
    chk("reset_rsp_cout", rsp_cout, 1'b0);
    chk("reset_rsp_ovf", rsp_ovf, 1'b0);
    chk("reset_rsp_id", rsp_id, 2'd0);
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single add with carry-out
    rsp_ready = 1'b1;
    set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    req_valid = 4'b0001;
    cycle();
    chk("t1_ready", g_ready, 4'b0001);
    chk("t1_valid", rsp_valid, 1'b1);
    chk("t1_sum", rsp_sum, 64'd0);
    chk("t1_cout", rsp_cout, 1'b1);
    chk("t1_ovf", rsp_ovf, 1'b0);
    chk("t1_id", rsp_id, 2'd0);

    // subtract with borrow; cin ignored
    set_req(2, 64'd5, 64'd7, 1'b1, 1'b0);
    req_valid = 4'b0100;
    cycle();
    chk("t2_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2_cout", rsp_cout, 1'b0);
    chk("t2_ovf", rsp_ovf, 1'b0);
    chk("t2_id", rsp_id, 2'd2);

    // signed overflow
    set_req(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    req_valid = 4'b1000;
    cycle();
    chk("t3_sum", rsp_sum, 64'h8000_0000_0000_0000);
    chk("t3_ovf", rsp_ovf, 1'b1);
    chk("t3_cout", rsp_cout, 1'b0);
    chk("t3_id", rsp_id, 2'd3);

    // round-robin with every requester valid
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
      cycle();
      chk("rr_grant", g_ready, 4'b0001 << order[k]);
      chk("rr_id", rsp_id, 64'(order[k]));
    end

    // backpressure: held response, no grant until the consumer accepts
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    set_req(1, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b1, 1'b1);
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    chk("bp_grant", g_ready, 4'b0010);
    chk("bp_id", rsp_id, 2'd1);
    chk("bp_sum", rsp_sum, 64'h0123_4567_89AB_CDEF - 64'h1111_1111_1111_1111);

    // asynchronous reset while a response is buffered
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    cycle();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_req_ready", req_ready, 4'b0000);
    chk("arst_rsp_sum", rsp_sum, 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    cycle();
    chk("arst_first_grant", g_ready, 4'b0010);

    // randomized traffic including edge operands
    for (int n = 0; n < 400; n++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NREQ; i++) begin
        case ($urandom_range(0, 5))
          0:       set_req(i, 64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
          1:       set_req(i, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'($urandom), 1'($urandom));
          default: set_req(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom));
        endcase
      end
      cycle();
    end

    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bk_adder_arbiter.md
Name: bk_adder_arbiter

Overview:
- Shares one 64-bit Brent-Kung adder (BrentKungAdder64Bit, instantiated internally) between NREQ requesters.
- Each requester uses a valid/ready handshake. Requesters are granted round-robin.
- Each operation is an add, or a subtract done as a + ~b + 1. The result goes into a single-entry registered response buffer with backpressure.
- Sits between the integer-issue ports and writeback as the shared wide-add resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester-id width; must equal ceil(log2(NREQ)).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; the handshake completes when valid and ready are both high.
- req_a  in  64*NREQ  operand a; requester i uses bits [64*i+63:64*i].
- req_b  in  64*NREQ  operand b, same packing.
- req_sub  in  NREQ  1 = subtract a-b, 0 = add.
- req_cin  in  NREQ  carry-in for add; ignored when sub=1.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_sum  out  64  result.
- rsp_cout  out  1  adder carry-out (for sub, 1 = no borrow).
- rsp_ovf  out  1  signed overflow: (a63 == b'63) && (sum63 != a63), where b' is the post-inversion operand.
- rsp_id  out  ID_W  index of the requester that produced this response.

Behaviour:
- Reset (async assert, sync-released use):
  - rsp_valid=0; rsp_sum=0, rsp_cout=0, rsp_ovf=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 while rst_n is low.
  - Reset mid-operation discards the buffered response with no replay.
- Buffer state machine, two states:
  - EMPTY (rsp_valid=0): a grant is allowed.
  - FULL (rsp_valid=1): a grant is allowed only in a cycle where rsp_ready=1 (drain and refill in the same cycle).
  - EMPTY->FULL on a grant. FULL->EMPTY on rsp_ready with no grant. FULL->FULL on rsp_ready with a grant, or on no rsp_ready.
- can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is one-hot on the winner when can_accept=1 and any valid is set; otherwise all zero.
  - req_ready never depends on req_a, req_b, req_sub or req_cin.
- Pointer update: on a grant to requester w, rr_ptr <= (w+1) mod NREQ. There is no update without a grant. Wrap NREQ-1 -> 0.
- Datapath (combinational from the winner's operands):
  - b' = sub ? ~b : b.
  - cin' = sub ? 1 : cin.
  - Adder computes {cout, sum} = a + b' + cin', modulo 2^64.
- Latency: the result is registered on the grant edge. rsp_valid goes high the cycle after the handshake, so there is 1 cycle from request accept to response visible.
- Throughput: 1 operation/cycle while rsp_ready stays high.
- Response stability: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.
- Requester rules:
  - A requester may drop req_valid without a grant; no state is kept for it.
  - Operands are sampled only on the grant cycle.
- Fairness: a continuously asserted requester is granted within NREQ grants. No starvation.
- Idle cycles (no valid): no state change except draining.

Test Plan:
- Reset then single add: req0 a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0, rsp_ready=1 -> req_ready[0]=1 the same cycle; next cycle rsp_valid=1, sum=0, cout=1, ovf=0, id=0.
- Subtract: req2 a=5, b=7, sub=1, req_cin=0 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0, id=2.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, add -> sum=0x8000_0000_0000_0000, ovf=1, cout=0.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles; rsp_id follows one cycle later.
- Backpressure: buffer FULL, rsp_ready=0 for 3 cycles with req1 valid -> req_ready=0 and rsp_* held stable; when rsp_ready=1, drain and grant req1 in the same cycle, and the new response appears next cycle.
- Async reset mid-stream: assert rst_n=0 while rsp_valid=1 between clock edges -> rsp_valid=0 and req_ready=0 immediately; after release the first grant goes to the lowest-index valid requester (rr_ptr=0).
